// File: rtl/compute_bw.sv
// rtl/compute_bw.sv - serial shift-add RGB to 8-bit grayscale converter
module compute_bw #(
    parameter int unsigned W_RED   = 77,
    parameter int unsigned W_GREEN = 150,
    parameter int unsigned W_BLUE  = 29
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] pixel_red,
    input  logic [7:0] pixel_green,
    input  logic [7:0] pixel_blue,
    input  logic       start,
    input  logic       clear,
    output logic       clear_flag,
    output logic [7:0] grayed_pixel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  red_q, red_d;
    logic [7:0]  green_q, green_d;
    logic [7:0]  blue_q, blue_d;
    logic [7:0]  gray_q, gray_d;
    logic        flag_q, flag_d;

    // Partial products for bit cnt_q of each latched channel.
    logic [16:0] term_red, term_green, term_blue, term_sum;

    always_comb begin
        term_red   = red_q[cnt_q]   ? (17'(W_RED)   << cnt_q) : 17'd0;
        term_green = green_q[cnt_q] ? (17'(W_GREEN) << cnt_q) : 17'd0;
        term_blue  = blue_q[cnt_q]  ? (17'(W_BLUE)  << cnt_q) : 17'd0;
        term_sum   = term_red + term_green + term_blue;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        gray_d  = gray_q;
        flag_d  = flag_q;

        case (state_q)
            IDLE: begin
                flag_d = 1'b0;
                // start has priority over a simultaneous clear here
                if (start) begin
                    red_d   = pixel_red;
                    green_d = pixel_green;
                    blue_d  = pixel_blue;
                    acc_d   = 17'd0;
                    cnt_d   = 3'd0;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (clear) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + term_sum;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ROUND;
                    end
                end
            end
            ROUND: begin
                if (clear) begin
                    state_d = IDLE;
                end else begin
                    // Max pre-round sum 65280 keeps the rounded result within 8 bits.
                    gray_d  = 8'((acc_q + 17'd128) >> 8);
                    flag_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (clear) begin
                    flag_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                flag_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            acc_q   <= 17'd0;
            cnt_q   <= 3'd0;
            red_q   <= 8'd0;
            green_q <= 8'd0;
            blue_q  <= 8'd0;
            gray_q  <= 8'd0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            gray_q  <= gray_d;
            flag_q  <= flag_d;
        end
    end

    assign clear_flag   = flag_q;
    assign grayed_pixel = gray_q;

endmodule

// File: tb/tb_compute_bw.sv
// tb/tb_compute_bw.sv - randomized self-checking bench for compute_bw
module tb_compute_bw;

    logic       clk;
    logic       n_rst;
    logic [7:0] pixel_red, pixel_green, pixel_blue;
    logic       start, clear;
    logic       clear_flag;
    logic [7:0] grayed_pixel;

    int n_checks = 0;
    int n_fail   = 0;

    compute_bw dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .pixel_red    (pixel_red),
        .pixel_green  (pixel_green),
        .pixel_blue   (pixel_blue),
        .start        (start),
        .clear        (clear),
        .clear_flag   (clear_flag),
        .grayed_pixel (grayed_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: weighted sum in 1/256 units, rounded half-up.
    function automatic int model(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b + 128) / 256;
    endfunction

    // Starts a conversion and waits (bounded) for clear_flag; lat = -1 on timeout.
    task automatic run_conv(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            output int lat, output logic [7:0] gray);
        @(negedge clk);
        pixel_red = r; pixel_green = g; pixel_blue = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (clear_flag) begin
                lat = k;
                break;
            end
        end
        gray = grayed_pixel;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (clear_flag !== 1'b0 || grayed_pixel !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_hold: flag=%b gray=%0d, required flag=0 gray=0", clear_flag, grayed_pixel);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (clear_flag !== 1'b0 || grayed_pixel !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_idle: flag=%b gray=%0d, required flag=0 gray=0", clear_flag, grayed_pixel);
        end
    endtask

    task automatic test_basic();
        int lat;
        int held;
        logic [7:0] gray;
        run_conv(8'd100, 8'd50, 8'd25, lat, gray);
        n_checks++;
        if (lat !== 9) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles, required 9", lat);
        end
        n_checks++;
        if (gray !== 8'd62) begin
            n_fail++;
            $display("FAIL basic_value: got %0d, required 62", gray);
        end
        held = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (clear_flag === 1'b1) held++;
        end
        n_checks++;
        if (held !== 25) begin
            n_fail++;
            $display("FAIL basic_hold: flag high %0d of 25 cycles, required 25", held);
        end
        do_clear();
        n_checks++;
        if (clear_flag !== 1'b0 || grayed_pixel !== 8'd62) begin
            n_fail++;
            $display("FAIL basic_clear: flag=%b gray=%0d, required flag=0 gray=62", clear_flag, grayed_pixel);
        end
    endtask

    task automatic test_corners();
        logic [7:0] cr [5] = '{8'd0, 8'd255, 8'd255, 8'd0,   8'd0};
        logic [7:0] cg [5] = '{8'd0, 8'd255, 8'd0,   8'd255, 8'd0};
        logic [7:0] cb [5] = '{8'd0, 8'd255, 8'd0,   8'd0,   8'd255};
        int exp_v [5] = '{0, 255, 77, 149, 29};
        int lat;
        logic [7:0] gray;
        for (int i = 0; i < 5; i++) begin
            run_conv(cr[i], cg[i], cb[i], lat, gray);
            n_checks++;
            if (lat !== 9 || int'(gray) !== exp_v[i]) begin
                n_fail++;
                $display("FAIL corner_%0d: lat=%0d gray=%0d, required lat=9 gray=%0d", i, lat, gray, exp_v[i]);
            end
            do_clear();
            n_checks++;
            if (clear_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL corner_clear_%0d: flag=%b, required 0", i, clear_flag);
            end
        end
    endtask

    task automatic test_sweep();
        int lat, g, b, diff, ideal;
        logic [7:0] gray;
        real exact;
        for (int r = 0; r <= 254; r++) begin
            g = (2 * r) % 256;
            b = (3 * r) % 256;
            run_conv(8'(r), 8'(g), 8'(b), lat, gray);
            exact = 0.299 * r + 0.587 * g + 0.114 * b;
            ideal = $rtoi(exact + 0.5);
            diff  = int'(gray) - ideal;
            if (diff < 0) diff = -diff;
            n_checks++;
            if (lat !== 9 || diff > 1) begin
                n_fail++;
                $display("FAIL sweep_err r=%0d g=%0d b=%0d: got %0d lat=%0d, required within 1 of %0d", r, g, b, gray, lat, ideal);
            end
            n_checks++;
            if (int'(gray) !== model(r, g, b)) begin
                n_fail++;
                $display("FAIL sweep_exact r=%0d g=%0d b=%0d: got %0d, required %0d", r, g, b, gray, model(r, g, b));
            end
            do_clear();
        end
    endtask

    task automatic test_random();
        int lat, r, g, b;
        logic [7:0] gray;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 255);
            g = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            run_conv(8'(r), 8'(g), 8'(b), lat, gray);
            n_checks++;
            if (lat !== 9 || int'(gray) !== model(r, g, b)) begin
                n_fail++;
                $display("FAIL random (%0d,%0d,%0d): got %0d lat=%0d, required %0d lat=9", r, g, b, gray, lat, model(r, g, b));
            end
            do_clear();
        end
    endtask

    // Inputs scrambled and a stray start pulsed mid-MUL; start pulsed again in DONE.
    task automatic test_input_change_and_start_ignored();
        int lat, r, g, b, expv;
        logic [7:0] gray;
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 255);
            g = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            expv = model(r, g, b);
            @(negedge clk);
            pixel_red = 8'(r); pixel_green = 8'(g); pixel_blue = 8'(b); start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat = -1;
            for (int k = 1; k <= 20; k++) begin
                if (k == 3) begin
                    pixel_red   = 8'($urandom_range(0, 255));
                    pixel_green = 8'($urandom_range(0, 255));
                    pixel_blue  = 8'($urandom_range(0, 255));
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                if (clear_flag) begin
                    lat = k;
                    break;
                end
            end
            start = 1'b0;
            n_checks++;
            if (lat !== 9 || int'(grayed_pixel) !== expv) begin
                n_fail++;
                $display("FAIL latched_inputs_%0d: got %0d lat=%0d, required %0d lat=9", i, grayed_pixel, lat, expv);
            end
            @(negedge clk);
            pixel_red = ~pixel_red; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (12) @(posedge clk);
            #1;
            n_checks++;
            if (clear_flag !== 1'b1 || int'(grayed_pixel) !== expv) begin
                n_fail++;
                $display("FAIL start_in_done_%0d: flag=%b gray=%0d, required flag=1 gray=%0d", i, clear_flag, grayed_pixel, expv);
            end
            do_clear();
            repeat (12) @(posedge clk);
            #1;
            n_checks++;
            if (clear_flag !== 1'b0 || int'(grayed_pixel) !== expv) begin
                n_fail++;
                $display("FAIL idle_after_clear_%0d: flag=%b gray=%0d, required flag=0 gray=%0d", i, clear_flag, grayed_pixel, expv);
            end
        end
    endtask

    // clear sampled at edge k after start (k=3 in MUL, k=9 in ROUND) aborts the conversion.
    task automatic test_clear_abort();
        int lat, rose;
        logic [7:0] gray, prev;
        int abort_at [2] = '{3, 9};
        run_conv(8'd10, 8'd20, 8'd30, lat, gray);
        do_clear();
        prev = gray;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            pixel_red = 8'd200; pixel_green = 8'd180; pixel_blue = 8'd160; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            rose = 0;
            for (int k = 1; k <= 20; k++) begin
                clear = (k == abort_at[i]);
                @(posedge clk); #1;
                if (clear_flag) rose++;
            end
            clear = 1'b0;
            n_checks++;
            if (rose !== 0 || grayed_pixel !== prev) begin
                n_fail++;
                $display("FAIL clear_abort_at_%0d: flag cycles=%0d gray=%0d, required 0 and gray=%0d", abort_at[i], rose, grayed_pixel, prev);
            end
        end
        run_conv(8'd200, 8'd180, 8'd160, lat, gray);
        n_checks++;
        if (lat !== 9 || int'(gray) !== model(200, 180, 160)) begin
            n_fail++;
            $display("FAIL after_abort: got %0d lat=%0d, required %0d lat=9", gray, lat, model(200, 180, 160));
        end
        do_clear();
    endtask

    task automatic test_async_reset();
        int lat;
        logic [7:0] gray;
        run_conv(8'd255, 8'd255, 8'd255, lat, gray);
        do_clear();
        @(negedge clk);
        pixel_red = 8'd90; pixel_green = 8'd90; pixel_blue = 8'd90; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if (clear_flag !== 1'b0 || grayed_pixel !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: flag=%b gray=%0d, required flag=0 gray=0", clear_flag, grayed_pixel);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (clear_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_discard: flag=%b, required 0", clear_flag);
        end
        run_conv(8'd100, 8'd50, 8'd25, lat, gray);
        n_checks++;
        if (lat !== 9 || gray !== 8'd62) begin
            n_fail++;
            $display("FAIL post_reset_conv: got %0d lat=%0d, required 62 lat=9", gray, lat);
        end
        do_clear();
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        pixel_red = 8'd0; pixel_green = 8'd0; pixel_blue = 8'd0;
        test_reset();
        test_basic();
        test_corners();
        test_sweep();
        test_random();
        test_input_change_and_start_ignored();
        test_clear_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
